// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default sizes for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_e;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDR_WIDTH    = 5;
    localparam int DEF_NUM_REGISTERS = 32;

    // Width of a requester index; never below one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_grant.sv
// Combinational round-robin picker: grants the first request at or after ptr_i.
module rr_grant
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
                idx_s = PTR_W'(sum_s - (PTR_W+1)'(NUM_REQ));
            end else begin
                idx_s = sum_s[PTR_W-1:0];
            end
            if (!found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register file.
// Optional power-up register clear is enabled by defining REGFILE_WB_INIT_CLEAR_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int PROC_DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int PROC_REGFILE_LOG2_DEEP = DEF_ADDR_WIDTH,
    parameter int NUM_REGISTERS          = DEF_NUM_REGISTERS,
    parameter int NUM_REQ                = 3
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQ-1:0]                        req_valid_i,
    input  logic [NUM_REQ*PROC_REGFILE_LOG2_DEEP-1:0] req_addr_i,
    input  logic [NUM_REQ*PROC_DATA_WIDTH-1:0]        req_data_i,
    output logic [NUM_REQ-1:0]                        req_ready_o,
    input  logic                                      halt_i,
    output logic                                      rf_write_en_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0]         rf_write_addr_o,
    output logic [PROC_DATA_WIDTH-1:0]                rf_write_data_o,
    output logic                                      init_done_o
);

    localparam int AW    = PROC_REGFILE_LOG2_DEEP;
    localparam int DW    = PROC_DATA_WIDTH;
    localparam int PTR_W = ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REGISTERS < 2 || NUM_REGISTERS > (1 << AW)) begin : g_param_err
        $error("regfile_wb_arbiter: unsupported parameter combination");
    end

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_s;
    logic               run_s, accept_s, wr_en_d;
    logic [PTR_W-1:0]   gnt_idx_s;
    logic [AW-1:0]      sel_addr_s, wr_addr_q;
    logic [DW-1:0]      sel_data_s, wr_data_q;
    logic               wr_en_q;

    rr_grant #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_grant (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant_s)
    );

    assign req_ready_o = (run_s && !halt_i) ? grant_s : '0;
    assign accept_s    = |(req_ready_o & req_valid_i);

    // Grant is one-hot, so an AND-OR mux selects the winner's payload and index.
    always_comb begin
        gnt_idx_s  = '0;
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_addr_s |= {AW{req_ready_o[k]}} & req_addr_i[k*AW +: AW];
            sel_data_s |= {DW{req_ready_o[k]}} & req_data_i[k*DW +: DW];
            gnt_idx_s  |= req_ready_o[k] ? PTR_W'(k) : '0;
        end
        if (accept_s) begin
            ptr_d = (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
        // Writes to register 0 are swallowed: accepted but never enabled.
        wr_en_d = accept_s && (sel_addr_s != '0);
    end

`ifdef REGFILE_WB_INIT_CLEAR_EN
    localparam int CNT_W = $clog2(NUM_REGISTERS + 1);

    wb_state_e        state_q;
    logic [CNT_W-1:0] clr_cnt_q;
    logic             init_done_q;

    assign run_s       = (state_q == RUN);
    assign init_done_o = init_done_q;

    // Clear sweep then arbitration; the counter runs one past the last register so done rises a cycle after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            clr_cnt_q   <= CNT_W'(1);
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == CNT_W'(NUM_REGISTERS)) begin
                        state_q     <= RUN;
                        wr_en_q     <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= AW'(clr_cnt_q);
                        wr_data_q <= '0;
                        clr_cnt_q <= clr_cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    ptr_q   <= ptr_d;
                    wr_en_q <= wr_en_d;
                    if (accept_s) begin
                        wr_addr_q <= sel_addr_s;
                        wr_data_q <= sel_data_s;
                    end
                end
                default: begin
                    state_q     <= CLEAR;
                    clr_cnt_q   <= CNT_W'(1);
                    wr_en_q     <= 1'b0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end
`else
    assign run_s       = 1'b1;
    assign init_done_o = 1'b1;

    // Arbitration only: pointer advance and one-cycle registered write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wr_en_q <= wr_en_d;
            if (accept_s) begin
                wr_addr_q <= sel_addr_s;
                wr_data_q <= sel_data_s;
            end
        end
    end
`endif

    assign rf_write_en_o   = wr_en_q;
    assign rf_write_addr_o = wr_addr_q;
    assign rf_write_data_o = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (both REGFILE_WB_INIT_CLEAR_EN builds).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        halt;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [15:0] rf_data;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .halt_i          (halt),
        .rf_write_en_o   (rf_we),
        .rf_write_addr_o (rf_addr),
        .rf_write_data_o (rf_data),
        .init_done_o     (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [15:0] d0, d1, d2;
        logic        halt;
        logic [2:0]  exp_ready;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [15:0] d0, d1, d2, input logic h);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        halt      = h;
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                                input logic [15:0] d0, d1, d2, input logic h,
                                input logic [2:0] er, input logic ee,
                                input logic [4:0] ea, input logic [15:0] ed);
        vec_t r;
        r.valid = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2; r.halt = h;
        r.exp_ready = er; r.exp_en = ee; r.exp_addr = ea; r.exp_data = ed;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(3'b000, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b000, 1'b0, 5'd0, 16'h0);
        vecs[1]  = mk(3'b111, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b001, 1'b1, 5'd5, 16'hA000);
        vecs[2]  = mk(3'b111, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b010, 1'b1, 5'd6, 16'hA001);
        vecs[3]  = mk(3'b111, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b100, 1'b1, 5'd7, 16'hA002);
        vecs[4]  = mk(3'b111, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b001, 1'b1, 5'd5, 16'hA000);
        vecs[5]  = mk(3'b111, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b010, 1'b1, 5'd6, 16'hA001);
        vecs[6]  = mk(3'b111, 5'd5, 5'd6, 5'd7, 16'hA000, 16'hA001, 16'hA002, 1'b0, 3'b100, 1'b1, 5'd7, 16'hA002);
        vecs[7]  = mk(3'b100, 5'd5, 5'd6, 5'd9, 16'hA000, 16'hA001, 16'h2222, 1'b0, 3'b100, 1'b1, 5'd9, 16'h2222);
        vecs[8]  = mk(3'b011, 5'd3, 5'd6, 5'd9, 16'h3333, 16'hA001, 16'h2222, 1'b0, 3'b001, 1'b1, 5'd3, 16'h3333);
        vecs[9]  = mk(3'b101, 5'd3, 5'd6, 5'd4, 16'h3333, 16'hA001, 16'h4444, 1'b0, 3'b100, 1'b1, 5'd4, 16'h4444);
        vecs[10] = mk(3'b010, 5'd3, 5'd0, 5'd4, 16'h3333, 16'hBEEF, 16'h4444, 1'b0, 3'b010, 1'b0, 5'd0, 16'h0);
        vecs[11] = mk(3'b000, 5'd3, 5'd0, 5'd4, 16'h3333, 16'hBEEF, 16'h4444, 1'b0, 3'b000, 1'b0, 5'd0, 16'h0);
        vecs[12] = mk(3'b011, 5'd12, 5'd8, 5'd4, 16'h5A5A, 16'h8888, 16'h4444, 1'b0, 3'b001, 1'b1, 5'd12, 16'h5A5A);
        vecs[13] = mk(3'b001, 5'd20, 5'd8, 5'd4, 16'h1357, 16'h8888, 16'h4444, 1'b1, 3'b000, 1'b0, 5'd0, 16'h0);
        vecs[14] = mk(3'b001, 5'd20, 5'd8, 5'd4, 16'h1357, 16'h8888, 16'h4444, 1'b1, 3'b000, 1'b0, 5'd0, 16'h0);
        vecs[15] = mk(3'b001, 5'd20, 5'd8, 5'd4, 16'h1357, 16'h8888, 16'h4444, 1'b0, 3'b001, 1'b1, 5'd20, 16'h1357);
        vecs[16] = mk(3'b010, 5'd20, 5'd17, 5'd4, 16'h1357, 16'h0F0F, 16'h4444, 1'b0, 3'b010, 1'b1, 5'd17, 16'h0F0F);
        vecs[17] = mk(3'b010, 5'd20, 5'd18, 5'd4, 16'h1357, 16'h1818, 16'h4444, 1'b1, 3'b000, 1'b0, 5'd0, 16'h0);
        vecs[18] = mk(3'b010, 5'd20, 5'd18, 5'd4, 16'h1357, 16'h1818, 16'h4444, 1'b0, 3'b010, 1'b1, 5'd18, 16'h1818);
        vecs[19] = mk(3'b110, 5'd20, 5'd19, 5'd21, 16'h1357, 16'h1919, 16'h2121, 1'b0, 3'b100, 1'b1, 5'd21, 16'h2121);

        rst = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_data", 32'(rf_data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
`ifdef REGFILE_WB_INIT_CLEAR_EN
        check("rst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b111, 5'd5, 5'd6, 5'd7, 16'h1, 16'h2, 16'h3, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            check($sformatf("clr_we_%0d", k), 32'(rf_we), 32'd1);
            check($sformatf("clr_addr_%0d", k), 32'(rf_addr), 32'(k));
            check($sformatf("clr_data_%0d", k), 32'(rf_data), 32'd0);
            check($sformatf("clr_ready_%0d", k), 32'(req_ready), 32'd0);
            check($sformatf("clr_done_%0d", k), 32'(init_done), 32'd0);
        end
        @(negedge clk);
        check("clr_done_final", 32'(init_done), 32'd1);
        check("clr_we_final", 32'(rf_we), 32'd0);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0);
`else
        check("rst_init_done", 32'(init_done), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b100, 5'd0, 5'd0, 5'd3, 16'h0, 16'h0, 16'h1234, 1'b0);
        #1;
        check("first_ready", 32'(req_ready), 32'b100);
        @(negedge clk);
        check("first_we", 32'(rf_we), 32'd1);
        check("first_addr", 32'(rf_addr), 32'd3);
        check("first_data", 32'(rf_data), 32'h1234);
`endif

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2,
                  vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].halt);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(negedge clk);
            check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                check($sformatf("v%0d_addr", i), 32'(rf_addr), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d_data", i), 32'(rf_data), 32'(vecs[i].exp_data));
            end
        end
        drive(3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("idle_we", 32'(rf_we), 32'd0);
        check("idle_addr_hold", 32'(rf_addr), 32'd21);

`ifdef REGFILE_WB_INIT_CLEAR_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        check("mid_clr_addr10", 32'(rf_addr), 32'd10);
        #2 rst = 1'b1;
        #1;
        check("mid_clr_rst_we", 32'(rf_we), 32'd0);
        check("mid_clr_rst_addr", 32'(rf_addr), 32'd0);
        check("mid_clr_rst_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_we", 32'(rf_we), 32'd1);
        check("restart_addr", 32'(rf_addr), 32'd1);
`else
        drive(3'b001, 5'd25, 5'd0, 5'd0, 16'h2525, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("mid_run_we", 32'(rf_we), 32'd1);
        check("mid_run_addr", 32'(rf_addr), 32'd25);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_run_rst_we", 32'(rf_we), 32'd0);
        check("mid_run_rst_addr", 32'(rf_addr), 32'd0);
        check("mid_run_rst_data", 32'(rf_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b111, 5'd11, 5'd12, 5'd13, 16'hC0DE, 16'h0, 16'h0, 1'b0);
        #1;
        check("post_rst_ptr_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        check("post_rst_we", 32'(rf_we), 32'd1);
        check("post_rst_addr", 32'(rf_addr), 32'd11);
        check("post_rst_data", 32'(rf_data), 32'hC0DE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter PROC_DATA_WIDTH, default 16, register data width.
REQ-002 SHALL have parameter PROC_REGFILE_LOG2_DEEP, default 5, register address width.
REQ-003 SHALL have parameter NUM_REGISTERS, default 32, register count.
REQ-004 SHALL have parameter NUM_REQ, default 3, number of write-back requesters (min 2).
REQ-005 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid_i  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port req_addr_i  input  NUM_REQ*PROC_REGFILE_LOG2_DEEP  flattened addresses; requester k at slice k.
REQ-009 SHALL have port req_data_i  input  NUM_REQ*PROC_DATA_WIDTH  flattened data; requester k at slice k.
REQ-010 SHALL have port req_ready_o  output  NUM_REQ  one-hot grant; transfer when valid&ready.
REQ-011 SHALL have port halt_i  input  1  blocks new grants while high.
REQ-012 SHALL have port rf_write_en_o  output  1  register-file write enable.
REQ-013 SHALL have port rf_write_addr_o  output  PROC_REGFILE_LOG2_DEEP  register-file write address.
REQ-014 SHALL have port rf_write_data_o  output  PROC_DATA_WIDTH  register-file write data.
REQ-015 SHALL have port init_done_o  output  1  high once register clear is complete.

Function
REQ-016 FSM SHALL have states CLEAR and RUN; CLEAR->RUN after last clear write; RUN is terminal until reset.
REQ-017 In CLEAR, SHALL issue one write per cycle of zero data to addresses 1..NUM_REGISTERS-1 ascending, rf_write_en_o=1, req_ready_o=0.
REQ-018 init_done_o SHALL rise the cycle after the write to NUM_REGISTERS-1 is presented and stay high until reset.
REQ-019 In RUN with halt_i=0, req_ready_o SHALL be combinational: exactly one bit set, for the first valid requester at or after the round-robin pointer; zero if no valid.
REQ-020 Round-robin pointer SHALL advance to (granted index+1) mod NUM_REQ on each accepted transfer; unchanged otherwise; reset value 0.
REQ-021 Accepted transfer SHALL appear on rf_write_* registered, exactly 1 cycle later, for exactly 1 cycle.
REQ-022 Accepted transfer with address 0 SHALL be consumed but SHALL produce rf_write_en_o=0.
REQ-023 With halt_i=1, req_ready_o SHALL be 0; a write already registered SHALL still complete.
REQ-024 With no accepted transfer, rf_write_en_o SHALL be 0 the next cycle; addr/data hold last value.
REQ-025 Throughput SHALL be one write per cycle with back-to-back grants permitted.
REQ-026 Requester SHALL hold valid/addr/data stable until accepted; block makes no ordering guarantee between requesters beyond round-robin.

Reset
REQ-027 rst_i high SHALL asynchronously force: state CLEAR (macro defined) or RUN (not defined), pointer 0, clear counter 1, rf_write_en_o 0, rf_write_addr_o 0, rf_write_data_o 0, init_done_o 0 (macro) or 1 (no macro).
REQ-028 Reset asserted mid-clear or mid-run SHALL abandon the pending write and restart from REQ-027 values on release.

Configuration
REQ-029 Macro REGFILE_WB_INIT_CLEAR_EN defined: CLEAR state and counter compiled in per REQ-016..018.
REQ-030 Macro not defined: no CLEAR state or counter; FSM starts in RUN, init_done_o constant 1, grants available first cycle after reset.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (CLEAR, RUN) and default width constants (data 16, address 5, registers 32).
REQ-032 Round-robin grant logic SHALL be sub-module rr_grant (NUM_REQ request vector + pointer in, one-hot grant out), purely combinational.

Verification
REQ-033 Clear: macro on, release reset -> 31 consecutive writes addr 1..31 data 0, then init_done_o=1, ready stays 0 throughout.
REQ-034 Round-robin: all 3 valid continuously, addr 5/6/7 -> grants 0,1,2,0,1,2; rf_write_addr_o 5,6,7,5,6,7 each one cycle later.
REQ-035 Zero address: req 1 valid addr 0 data 16'hBEEF -> ready 1 for one cycle, rf_write_en_o stays 0.
REQ-036 Halt: halt_i=1 with req 0 valid -> ready 0 for all halted cycles; halt drop -> grant next cycle, write the cycle after.
REQ-037 Reset mid-clear at address 10 -> outputs 0 immediately; on release clear restarts at address 1.
REQ-038 Macro off: req 2 valid addr 3 data 16'h1234 first cycle after reset -> rf_write_en_o=1, addr 3, data 16'h1234 next cycle.
